// File: rtl/voice_motion_ctrl_if.sv
// Frame-rate handshake between the Signal_Analyser/frame timer side and the
// motion controller, plus the sprite position fed to the renderer.
interface voice_motion_ctrl_if;
  logic       frame_tick;
  logic [1:0] pitch;
  logic       volumn;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic       jumping;
  logic       move_valid;

  modport master (
    output frame_tick, pitch, volumn,
    input  x_pos, y_pos, jumping, move_valid
  );

  modport slave (
    input  frame_tick, pitch, volumn,
    output x_pos, y_pos, jumping, move_valid
  );
endinterface

// File: rtl/voice_motion_ctrl.sv
// Voice-driven character motion: volume debounce triggers a ground/rise/apex/fall
// jump, a stable pitch picks the horizontal speed; all state advances once per frame.
module voice_motion_ctrl #(
  parameter int X_MAX       = 159,
  parameter int GROUND_Y    = 100,
  parameter int JUMP_H      = 40,
  parameter int RISE_STEP   = 2,
  parameter int APEX_FRAMES = 4,
  parameter int DEBOUNCE    = 3,
  parameter int SLOW_STEP   = 1,
  parameter int FAST_STEP   = 2
) (
  input logic                 clk,
  input logic                 resetn,
  voice_motion_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {GROUND, RISE, APEX, FALL} state_e;

  localparam int VW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(APEX_FRAMES + 1);

  localparam logic [6:0]    Y_GND     = 7'(GROUND_Y);
  localparam logic [6:0]    Y_TOP     = 7'(GROUND_Y - JUMP_H);
  localparam logic [6:0]    Y_STEP    = 7'(RISE_STEP);
  localparam logic [8:0]    X_LIM     = 9'(X_MAX);
  localparam logic [8:0]    X_WRAP    = 9'(X_MAX + 1);
  localparam logic [7:0]    SPD_SLOW  = 8'(SLOW_STEP);
  localparam logic [7:0]    SPD_FAST  = 8'(FAST_STEP);
  localparam logic [VW-1:0] DEB_MAX   = VW'(DEBOUNCE);
  localparam logic [AW-1:0] APEX_LAST = AW'(APEX_FRAMES - 1);

  logic [1:0]    pitch_m_q, pitch_s_q, pitch_prev_q;
  logic          vol_m_q, vol_s_q;
  state_e        state_q;
  logic [7:0]    x_q, speed_q;
  logic [6:0]    y_q;
  logic          jumping_q, move_valid_q, armed_q;
  logic [VW-1:0] vol_cnt_q;
  logic [AW-1:0] apex_cnt_q;

  logic [VW-1:0] vol_cnt_d;
  logic          armed_d, trig;
  logic [7:0]    speed_d, x_d;
  logic [8:0]    x_sum;

  // Per-frame values that both the datapath registers and the FSM consume.
  always_comb begin
    vol_cnt_d = '0;
    armed_d   = 1'b1;
    if (vol_s_q) begin
      vol_cnt_d = (vol_cnt_q == DEB_MAX) ? vol_cnt_q : vol_cnt_q + 1'b1;
      armed_d   = armed_q;
    end
    trig = (state_q == GROUND) && armed_q && (vol_cnt_d == DEB_MAX);
    if (trig) armed_d = 1'b0;

    speed_d = speed_q;
    if (pitch_s_q == pitch_prev_q) begin
      unique case (pitch_s_q)
        2'b01:   speed_d = SPD_SLOW;
        2'b11:   speed_d = SPD_FAST;
        default: speed_d = '0;
      endcase
    end

    x_sum = {1'b0, x_q} + {1'b0, speed_d};
    x_d   = (x_sum > X_LIM) ? 8'(x_sum - X_WRAP) : x_sum[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments only; any value needed
  // twice in the same frame is computed combinationally above instead.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pitch_m_q    <= 2'b00;
      pitch_s_q    <= 2'b00;
      vol_m_q      <= 1'b0;
      vol_s_q      <= 1'b0;
      pitch_prev_q <= 2'b00;
      state_q      <= GROUND;
      x_q          <= '0;
      y_q          <= Y_GND;
      speed_q      <= '0;
      jumping_q    <= 1'b0;
      move_valid_q <= 1'b0;
      armed_q      <= 1'b1;
      vol_cnt_q    <= '0;
      apex_cnt_q   <= '0;
    end else begin
      pitch_m_q    <= bus.pitch;
      pitch_s_q    <= pitch_m_q;
      vol_m_q      <= bus.volumn;
      vol_s_q      <= vol_m_q;
      move_valid_q <= bus.frame_tick;
      if (bus.frame_tick) begin
        vol_cnt_q    <= vol_cnt_d;
        armed_q      <= armed_d;
        pitch_prev_q <= pitch_s_q;
        speed_q      <= speed_d;
        x_q          <= x_d;
        unique case (state_q)
          GROUND: begin
            y_q <= Y_GND;
            if (trig) begin
              state_q   <= RISE;
              jumping_q <= 1'b1;
            end
          end
          RISE: begin
            if (y_q <= Y_TOP + Y_STEP) begin
              y_q        <= Y_TOP;
              apex_cnt_q <= '0;
              state_q    <= APEX;
            end else begin
              y_q <= y_q - Y_STEP;
            end
          end
          APEX: begin
            apex_cnt_q <= apex_cnt_q + 1'b1;
            if (apex_cnt_q == APEX_LAST) state_q <= FALL;
          end
          FALL: begin
            if (y_q >= Y_GND - Y_STEP) begin
              y_q       <= Y_GND;
              state_q   <= GROUND;
              jumping_q <= 1'b0;
            end else begin
              y_q <= y_q + Y_STEP;
            end
          end
          default: state_q <= GROUND;
        endcase
      end
    end
  end

  assign bus.x_pos      = x_q;
  assign bus.y_pos      = y_q;
  assign bus.jumping    = jumping_q;
  assign bus.move_valid = move_valid_q;

endmodule

// File: tb/tb_voice_motion_ctrl.sv
// Randomized self-checking bench for voice_motion_ctrl against a frame-level
// model that replays precomputed jump trajectories.
module tb_voice_motion_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  voice_motion_ctrl_if bus ();

  voice_motion_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Frame-level reference state.
  int mx, my, mj, m_speed, loud_run, m_prev_y;
  bit m_armed;
  logic [1:0] m_prev_pitch;
  int yq[$];
  int jq[$];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 100; mj = 0; m_speed = 0; loud_run = 0; m_prev_y = 100;
    m_armed = 1'b1; m_prev_pitch = 2'b00;
    yq.delete(); jq.delete();
  endtask

  task automatic build_jump();
    int y;
    y = 100;
    yq.push_back(100); jq.push_back(1);
    while (y > 60) begin
      y = (y - 2 < 60) ? 60 : y - 2;
      yq.push_back(y); jq.push_back(1);
    end
    repeat (4) begin yq.push_back(60); jq.push_back(1); end
    while (y < 100) begin
      y = (y + 2 > 100) ? 100 : y + 2;
      yq.push_back(y); jq.push_back(y != 100);
    end
  endtask

  task automatic model_step(input logic [1:0] p, input logic v);
    bit trig;
    if (v) loud_run++;
    else begin loud_run = 0; m_armed = 1'b1; end
    trig = (yq.size() == 0) && m_armed && (loud_run >= 3);
    if (trig) m_armed = 1'b0;
    if (p == m_prev_pitch) m_speed = (p == 2'b01) ? 1 : (p == 2'b11) ? 2 : 0;
    m_prev_pitch = p;
    mx = (mx + m_speed) % 160;
    if (trig) build_jump();
    m_prev_y = my;
    if (yq.size() != 0) begin
      my = yq.pop_front(); mj = jq.pop_front();
    end else begin
      my = 100; mj = 0;
    end
  endtask

  task automatic do_frame(input logic [1:0] p, input logic v);
    @(negedge clk);
    bus.pitch = p; bus.volumn = v;
    repeat (3) @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    model_step(p, v);
    check("x_pos", int'(bus.x_pos), mx);
    check("y_pos", int'(bus.y_pos), my);
    check("jumping", int'(bus.jumping), mj);
    check("move_valid_hi", int'(bus.move_valid), 1);
    @(negedge clk);
    check("move_valid_lo", int'(bus.move_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic [1:0] rp;
    logic rv;
    bus.frame_tick = 1'b0;
    bus.pitch = 2'b00;
    bus.volumn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_x", int'(bus.x_pos), 0);
    check("rst_y", int'(bus.y_pos), 100);
    check("rst_jumping", int'(bus.jumping), 0);
    check("rst_move_valid", int'(bus.move_valid), 0);
    resetn = 1'b1;

    repeat (10) do_frame(2'b00, 1'b0);

    // Steady fast pitch, one slow glitch frame, then fast again.
    repeat (6) do_frame(2'b11, 1'b0);
    do_frame(2'b01, 1'b0);
    repeat (3) do_frame(2'b11, 1'b0);

    // Walk to the right edge and wrap, then stop on the invalid code.
    guard = 0;
    while (mx != 158 && guard < 200) begin
      do_frame(2'b11, 1'b0);
      guard++;
    end
    check("reach_x158", mx, 158);
    do_frame(2'b11, 1'b0);
    repeat (4) do_frame(2'b10, 1'b0);

    // Sustained loud: one jump only; a quiet frame re-arms the next one.
    repeat (60) do_frame(2'b00, 1'b1);
    do_frame(2'b00, 1'b0);
    repeat (50) do_frame(2'b01, 1'b1);

    // Too short and alternating loudness never jumps.
    repeat (2) do_frame(2'b00, 1'b1);
    do_frame(2'b00, 1'b0);
    repeat (10) begin
      do_frame(2'b00, 1'b0);
      do_frame(2'b00, 1'b1);
    end

    // Jump again and reset asynchronously while falling through y=80.
    do_frame(2'b00, 1'b0);
    guard = 0;
    while (!(my == 80 && my > m_prev_y) && guard < 80) begin
      do_frame(2'b11, 1'b1);
      guard++;
    end
    check("reach_fall_y80", my, 80);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_y", int'(bus.y_pos), 100);
    check("async_rst_x", int'(bus.x_pos), 0);
    check("async_rst_jumping", int'(bus.jumping), 0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    repeat (3) do_frame(2'b00, 1'b0);

    // Randomized frames: sticky pitch and loudness runs.
    rp = 2'b00;
    rv = 1'b0;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) rp = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) rv = ~rv;
      do_frame(rp, rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
